// File: rtl/saph_span_interp.sv
// Span sequencer: restoring divide sets the DDA step, then one RGBA pixel per span position.
// Define SAPH_SPAN_PARALLEL_EN for four interpolators (1 px/cycle); default is one shared interpolator.

module saph_ch_interp (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] t,
    output logic [7:0] y
);
    logic [8:0] w;
    logic [8:0] nw;

    // Weight 0..255 is stretched to 0..256 so t=255 returns b exactly.
    assign w  = {1'b0, t} + {8'b0, t[7]};
    assign nw = 9'd256 - w;
    assign y  = 8'((16'(a) * 16'(nw) + 16'(b) * 16'(w)) >> 8);
endmodule

module saph_span_interp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_from,
    input  logic [31:0] cmd_to,
    input  logic [7:0]  cmd_len,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [31:0] px_data,
    output logic        px_last,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RUN} state_t;

    state_t      state, state_nx;
    logic [31:0] from_r, to_r;
    logic [7:0]  d, q, rem, coeff, idx;
    logic [8:0]  err, err_sum, rem_sh;
    logic [2:0]  div_cnt;
    logic        gen_done, accept, px_hs, out_free, compute, produce, is_last, rem_ge;
    logic [31:0] pix;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_ready && cmd_valid;
    assign px_hs     = px_valid && px_ready;
    assign out_free  = !px_valid || px_ready;
    assign compute   = (state == S_RUN) && !gen_done;
    assign is_last   = (idx == d);
    assign rem_sh    = {rem, 1'b1};
    assign rem_ge    = (rem_sh >= {1'b0, d});
    assign err_sum   = err + {1'b0, rem};

`ifdef SAPH_SPAN_PARALLEL_EN
    for (genvar k = 0; k < 4; k++) begin : g_ch
        saph_ch_interp u_interp (
            .a(from_r[8*k +: 8]),
            .b(to_r[8*k +: 8]),
            .t(coeff),
            .y(pix[8*k +: 8])
        );
    end
    assign produce = compute && out_free;
`else
    logic [1:0]  ch;
    logic [23:0] stage;
    logic [7:0]  cy;

    saph_ch_interp u_interp (
        .a(from_r[{ch, 3'b000} +: 8]),
        .b(to_r[{ch, 3'b000} +: 8]),
        .t(coeff),
        .y(cy)
    );
    assign pix     = {cy, stage};
    assign produce = compute && (ch == 2'd3) && out_free;

    // Channel 3 bypasses staging and lands in the output register with the staged bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch    <= '0;
            stage <= '0;
        end else if (accept) begin
            ch <= '0;
        end else if (compute && ch != 2'd3) begin
            stage[{ch, 3'b000} +: 8] <= cy;
            ch                       <= ch + 2'd1;
        end else if (produce) begin
            ch <= '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_DIV;
            S_DIV:   if (div_cnt == 3'd7) state_nx = S_RUN;
            S_RUN:   if (px_hs && px_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            from_r   <= '0;
            to_r     <= '0;
            d        <= '0;
            q        <= '0;
            rem      <= '0;
            coeff    <= '0;
            idx      <= '0;
            err      <= '0;
            div_cnt  <= '0;
            gen_done <= 1'b0;
            px_valid <= 1'b0;
            px_data  <= '0;
            px_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    from_r   <= cmd_from;
                    to_r     <= cmd_to;
                    d        <= cmd_len - 8'd1;
                    q        <= '0;
                    rem      <= '0;
                    coeff    <= '0;
                    idx      <= '0;
                    err      <= '0;
                    div_cnt  <= '0;
                    gen_done <= 1'b0;
                end
                S_DIV: begin
                    div_cnt <= div_cnt + 3'd1;
                    q       <= {q[6:0], rem_ge};
                    rem     <= rem_ge ? 8'(rem_sh - {1'b0, d}) : rem_sh[7:0];
                    if (div_cnt == 3'd7 && d == 8'd0) begin
                        q   <= '0;
                        rem <= '0;
                    end
                end
                S_RUN: if (produce) begin
                    gen_done <= is_last;
                    idx      <= idx + 8'd1;
                    // Skip the step after the final pixel so coeff stays at 255.
                    if (!is_last) begin
                        if (err_sum >= {1'b0, d}) begin
                            err   <= err_sum - {1'b0, d};
                            coeff <= coeff + q + 8'd1;
                        end else begin
                            err   <= err_sum;
                            coeff <= coeff + q;
                        end
                    end
                end
                default: ;
            endcase

            if (produce) begin
                px_valid <= 1'b1;
                px_data  <= pix;
                px_last  <= is_last;
            end else if (px_hs) begin
                px_valid <= 1'b0;
                px_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_saph_span_interp.sv
// Directed bench for saph_span_interp: reset, short/uneven/full spans, backpressure, mid-run reset.
module tb_saph_span_interp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_from;
    logic [31:0] cmd_to;
    logic [7:0]  cmd_len;
    logic        px_valid;
    logic        px_ready;
    logic [31:0] px_data;
    logic        px_last;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    saph_span_interp dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_from(cmd_from), .cmd_to(cmd_to), .cmd_len(cmd_len),
        .px_valid(px_valid), .px_ready(px_ready),
        .px_data(px_data), .px_last(px_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_cmd(input logic [31:0] f, input logic [31:0] t, input logic [7:0] l);
        int unsigned n = 0;
        while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
        cmd_from = f; cmd_to = t; cmd_len = l; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_px(output logic [31:0] data, output logic last);
        int unsigned n = 0;
        px_ready = 1'b1;
        while (!px_valid && n < 2000) begin @(posedge clk); #1; n++; end
        if (px_valid) begin
            data = px_data; last = px_last;
            @(posedge clk); #1;
        end else begin
            data = 'x; last = 1'bx;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_from = '0; cmd_to = '0; cmd_len = '0; px_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (px_valid !== 1'b0) begin n_err++; $display("FAIL reset_px_valid got %b want 0", px_valid); end
        n_cmp++; if (px_data !== 32'h0) begin n_err++; $display("FAIL reset_px_data got %h want 0", px_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_len1;
        logic [31:0] d; logic l;
        send_cmd(32'h11223344, 32'hFFFFFFFF, 8'd1);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL len1_busy got %b want 1", busy); end
        get_px(d, l);
        n_cmp++; if (d !== 32'h11223344) begin n_err++; $display("FAIL len1_data got %h want 11223344", d); end
        n_cmp++; if (l !== 1'b1) begin n_err++; $display("FAIL len1_last got %b want 1", l); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL len1_ready_after got %b want 1", cmd_ready); end
    endtask

    task automatic test_len2;
        logic [31:0] d; logic l;
        send_cmd(32'h00000000, 32'hFFFFFFFF, 8'd2);
        get_px(d, l);
        n_cmp++; if (d !== 32'h00000000 || l !== 1'b0) begin n_err++; $display("FAIL len2_px0 got %h/%b want 00000000/0", d, l); end
        get_px(d, l);
        n_cmp++; if (d !== 32'hFFFFFFFF || l !== 1'b1) begin n_err++; $display("FAIL len2_px1 got %h/%b want ffffffff/1", d, l); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL len2_ready_after got %b want 1", cmd_ready); end
    endtask

    task automatic test_uneven;
        logic [31:0] exp_px [4] = '{32'h000000FF, 32'h000000AA, 32'h00000054, 32'h00000000};
        logic [31:0] d; logic l;
        send_cmd(32'h000000FF, 32'h00000000, 8'd4);
        for (int i = 0; i < 4; i++) begin
            get_px(d, l);
            n_cmp++;
            if (d !== exp_px[i] || l !== (i == 3)) begin
                n_err++; $display("FAIL uneven_px%0d got %h/%b want %h/%b", i, d, l, exp_px[i], (i == 3));
            end
        end
    endtask

    task automatic test_full_span;
        logic [31:0] pix [256];
        logic        lst [256];
        int unsigned lat = 0;
        int unsigned bad_last = 0;
        int unsigned exp_lat;
`ifdef SAPH_SPAN_PARALLEL_EN
        exp_lat = 9;
`else
        exp_lat = 12;
`endif
        send_cmd(32'h00000000, 32'hFFFFFFFF, 8'd0);
        px_ready = 1'b1;
        while (!px_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL full_latency got %0d want %0d", lat, exp_lat); end
        for (int i = 0; i < 256; i++) get_px(pix[i], lst[i]);
        n_cmp++; if (pix[0] !== 32'h00000000) begin n_err++; $display("FAIL full_px0 got %h want 00000000", pix[0]); end
        n_cmp++; if (pix[128] !== 32'h80808080) begin n_err++; $display("FAIL full_px128 got %h want 80808080", pix[128]); end
        n_cmp++; if (pix[255] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL full_px255 got %h want ffffffff", pix[255]); end
        for (int i = 0; i < 256; i++) if (lst[i] !== (i == 255)) bad_last++;
        n_cmp++; if (bad_last !== 0) begin n_err++; $display("FAIL full_last_flags got %0d wrong want 0", bad_last); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after got %b want 1", cmd_ready); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_px [4] = '{32'h000000FF, 32'h000000AA, 32'h00000054, 32'h00000000};
        logic [31:0] d, held; logic l;
        int unsigned n = 0;
        int unsigned unstable = 0;
        int unsigned extra = 0;
        send_cmd(32'h000000FF, 32'h00000000, 8'd4);
        get_px(d, l);
        n_cmp++; if (d !== exp_px[0]) begin n_err++; $display("FAIL bp_px0 got %h want %h", d, exp_px[0]); end
        px_ready = 1'b0;
        while (!px_valid && n < 100) begin @(posedge clk); #1; n++; end
        held = px_data;
        cmd_from = 32'hDEADBEEF; cmd_to = 32'h0; cmd_len = 8'd1; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (px_valid !== 1'b1 || px_data !== held || px_last !== 1'b0) unstable++;
        end
        cmd_valid = 1'b0;
        n_cmp++; if (held !== exp_px[1]) begin n_err++; $display("FAIL bp_held got %h want %h", held, exp_px[1]); end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
        for (int i = 1; i < 4; i++) begin
            get_px(d, l);
            n_cmp++;
            if (d !== exp_px[i] || l !== (i == 3)) begin
                n_err++; $display("FAIL bp_px%0d got %h/%b want %h/%b", i, d, l, exp_px[i], (i == 3));
            end
        end
        for (int i = 0; i < 20; i++) begin
            if (px_valid !== 1'b0 || cmd_ready !== 1'b1) extra++;
            @(posedge clk); #1;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL bp_idle_after got %0d bad cycles want 0", extra); end
    endtask

    task automatic test_reset_midrun;
        logic [7:0] exp_b [8] = '{8'h00, 8'h23, 8'h47, 8'h6C, 8'h91, 8'hB6, 8'hDA, 8'hFF};
        logic [31:0] d; logic l;
        int unsigned n = 0;
        send_cmd(32'h00000000, 32'hFFFFFFFF, 8'd8);
        get_px(d, l);
        get_px(d, l);
        n_cmp++; if (d !== {4{exp_b[1]}}) begin n_err++; $display("FAIL rst_pre_px1 got %h want %h", d, {4{exp_b[1]}}); end
        px_ready = 1'b0;
        while (!px_valid && n < 100) begin @(posedge clk); #1; n++; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || px_valid !== 1'b0 || px_last !== 1'b0 || px_data !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_outputs got rdy=%b busy=%b v=%b last=%b data=%h want 1/0/0/0/0",
                     cmd_ready, busy, px_valid, px_last, px_data);
        end
        send_cmd(32'h00000000, 32'hFFFFFFFF, 8'd8);
        for (int i = 0; i < 8; i++) begin
            get_px(d, l);
            n_cmp++;
            if (d !== {4{exp_b[i]}} || l !== (i == 7)) begin
                n_err++; $display("FAIL rst_seq_px%0d got %h/%b want %h/%b", i, d, l, {4{exp_b[i]}}, (i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_len1();
        test_len2();
        test_uneven();
        test_full_span();
        test_backpressure();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
